puc_stable: RTL and testbench
=============================

# puc_stable

Parametrised power-up contract unit for the uncore. It samples an N-bit vector of capability pins through a synchroniser and normalises each pin's polarity. It latches the contract only after the vector has held stable for a programmable number of cycles. A timeout forces a lock if the pins never settle, and an optional four-phase handshake lets uncore control logic re-latch the contract without a full reset.

## Interface
- N_CAP, 4, number of capability pins
- CAP_INV, {N_CAP{1'b1}}, per-bit inversion mask; 1 = pin is active-low and is inverted to active-high
- STABLE_CYCLES, 8, consecutive identical samples required to lock; minimum 2
- TIMEOUT_CYCLES, 64, SAMPLE-state cycles before a forced lock; must be greater than STABLE_CYCLES
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- cap_i  in  N_CAP  raw capability pins, asynchronous to clk_i
- relatch_req_i  in  1  re-latch request (four-phase)
- relatch_ack_o  out  1  re-latch acknowledge
- puc_o  out  N_CAP  latched, normalised contract
- puc_valid_o  out  1  contract locked
- puc_glitch_o  out  1  sticky: candidate changed at least once during the current sampling window
- puc_timeout_o  out  1  sticky: lock was forced by timeout

## Operation
- Sampling path:
  - cap_i passes through a 2-stage synchroniser.
  - Normalised sample: norm = sync ^ CAP_INV.
- FSM states: FILL, SAMPLE, LOCKED. Reset state is FILL.
- FILL:
  - Lasts exactly 2 cycles, which flushes the synchroniser.
  - Then moves to SAMPLE with cnt=0 and tmo=0.
- SAMPLE, evaluated each cycle; tmo increments every cycle:
  - cnt==0: cand<=norm, cnt<=1, no glitch.
  - norm==cand: cnt<=cnt+1. If cnt+1==STABLE_CYCLES, then puc_o<=cand and the FSM moves to LOCKED.
  - norm!=cand: cand<=norm, cnt<=1, puc_glitch_o<=1.
  - tmo+1==TIMEOUT_CYCLES with no stable lock on that edge: puc_o<=norm, puc_timeout_o<=1, FSM moves to LOCKED.
  - Stable lock and timeout on the same edge: stable lock wins and puc_timeout_o stays 0.
- LOCKED:
  - puc_valid_o=1. Pins are ignored. puc_o is frozen.
  - The state is terminal unless a re-latch is accepted (see Configuration).
- Re-latch, four-phase handshake:
  - Accepted only in LOCKED, on relatch_req_i=1, while ack is low and the req-low-seen flag is set.
  - On the next edge: SAMPLE, cnt=0, tmo=0, glitch and timeout flags cleared, puc_valid_o=0.
  - puc_o holds its previous value until the new lock.
  - On the re-lock, relatch_ack_o<=1. It stays high while relatch_req_i stays high and falls on the edge after req is seen low.
  - A new re-latch needs req low for at least one cycle after ack falls.
  - A req arriving in FILL or SAMPLE is not acted on until LOCKED.
- Counter widths: $clog2(STABLE_CYCLES+1) for cnt and $clog2(TIMEOUT_CYCLES+1) for tmo. No wrap is possible in valid states.

## Timing
- Reset values:
  - puc_o = 0
  - puc_valid_o = 0
  - puc_glitch_o = 0
  - puc_timeout_o = 0
  - relatch_ack_o = 0
  - cand = 0, cnt = 0, tmo = 0
  - synchroniser = 0
- Reset asserted mid-operation clears all state immediately, in any state.
- Constant pins: puc_valid_o and the new puc_o appear after clock edge 2+STABLE_CYCLES following reset deassertion (edge 10 with defaults).
- Forced lock: after edge 2+TIMEOUT_CYCLES (edge 66 with defaults).
- Re-latch with constant pins: valid falls 1 edge after req is accepted. Valid and ack rise STABLE_CYCLES edges after that.
- Pin-to-sample latency is 2 cycles.
- All outputs are registered.

## Configuration
- PUC_RELATCH_EN defined: the re-latch handshake is functional as described above.
- PUC_RELATCH_EN undefined:
  - relatch_req_i is ignored and relatch_ack_o is tied to 0.
  - LOCKED is terminal until reset.
  - The ports are present in both builds.

## Structure
- Package puc_pkg contains:
  - puc_state_t enum {PUC_FILL, PUC_SAMPLE, PUC_LOCKED}
  - localparam PUC_SYNC_STAGES = 2
- Sub-module puc_sync: a parametrised-width, PUC_SYNC_STAGES-deep flop synchroniser with asynchronous reset to 0.
- The FSM, counters and handshake live in puc_stable.

## Test plan
- Defaults, cap_i=4'b0101 held → puc_valid_o rises after edge 10, puc_o=4'b1010, glitch=0, timeout=0.
- cap_i toggles bit0 at edge 6, then holds → puc_glitch_o=1, lock delayed to 8 stable samples after the change, puc_o reflects the final value.
- cap_i toggles every 3 cycles → forced lock after edge 66, puc_timeout_o=1, puc_o = normalised sample at that edge.
- PUC_RELATCH_EN, locked on 4'b1010, change cap_i to 4'b1111 (normalised 0000), raise req → valid falls next edge, puc_o holds 1010, then valid and ack rise with puc_o=0000, ack falls after req drops.
- Assert reset_i mid-SAMPLE and again in LOCKED → all outputs 0 immediately without a clock, full sequence restarts from FILL.
- PUC_RELATCH_EN undefined, req held high in LOCKED → state, puc_o and valid unchanged, relatch_ack_o=0.

Source files
------------

// File: rtl/puc_pkg.sv
// Shared types and constants for the power-up contract unit.
package puc_pkg;

  typedef enum logic [1:0] {
    PUC_FILL,
    PUC_SAMPLE,
    PUC_LOCKED
  } puc_state_t;

  localparam int unsigned PUC_SYNC_STAGES = 2;

endpackage

// File: rtl/puc_sync.sv
// Multi-flop synchroniser for the asynchronous capability pins; resets to zero.
module puc_sync
  import puc_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [PUC_SYNC_STAGES];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < PUC_SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < PUC_SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q_o = r_stage[PUC_SYNC_STAGES-1];

endmodule

// File: rtl/puc_stable.sv
// Power-up contract unit: debounces normalised capability pins and latches them once stable.
// Define PUC_RELATCH_EN to enable the four-phase re-latch handshake.
module puc_stable
  import puc_pkg::*;
#(
  parameter int unsigned      N_CAP          = 4,
  parameter logic [N_CAP-1:0] CAP_INV        = {N_CAP{1'b1}},
  parameter int unsigned      STABLE_CYCLES  = 8,
  parameter int unsigned      TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_CAP-1:0] cap_i,
  input  logic             relatch_req_i,
  output logic             relatch_ack_o,
  output logic [N_CAP-1:0] puc_o,
  output logic             puc_valid_o,
  output logic             puc_glitch_o,
  output logic             puc_timeout_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [N_CAP-1:0] w_sync;
  logic [N_CAP-1:0] w_norm;

  puc_sync #(
    .WIDTH(N_CAP)
  ) u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (cap_i),
    .q_o    (w_sync)
  );

  assign w_norm = w_sync ^ CAP_INV;

  puc_state_t       r_state, w_state_next;
  logic             r_fill, w_fill_next;
  logic [N_CAP-1:0] r_cand, w_cand_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [TMO_W-1:0] r_tmo, w_tmo_next, w_tmo_inc;
  logic [N_CAP-1:0] r_puc, w_puc_next;
  logic             r_valid, w_valid_next;
  logic             r_glitch, w_glitch_next;
  logic             r_timeout, w_timeout_next;
  logic             w_stable;
  logic             w_lock;
  logic             w_accept;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tmo_inc = r_tmo + TMO_W'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= PUC_FILL;
      r_fill    <= 1'b0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_puc     <= '0;
      r_valid   <= 1'b0;
      r_glitch  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_fill    <= w_fill_next;
      r_cand    <= w_cand_next;
      r_cnt     <= w_cnt_next;
      r_tmo     <= w_tmo_next;
      r_puc     <= w_puc_next;
      r_valid   <= w_valid_next;
      r_glitch  <= w_glitch_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_fill_next    = r_fill;
    w_cand_next    = r_cand;
    w_cnt_next     = r_cnt;
    w_tmo_next     = r_tmo;
    w_puc_next     = r_puc;
    w_valid_next   = r_valid;
    w_glitch_next  = r_glitch;
    w_timeout_next = r_timeout;
    w_stable       = 1'b0;
    w_lock         = 1'b0;
    unique case (r_state)
      PUC_FILL: begin
        // Two cycles flush the synchroniser before any sample is trusted.
        if (r_fill) begin
          w_state_next = PUC_SAMPLE;
          w_fill_next  = 1'b0;
          w_cnt_next   = '0;
          w_tmo_next   = '0;
        end else begin
          w_fill_next = 1'b1;
        end
      end
      PUC_SAMPLE: begin
        w_tmo_next = w_tmo_inc;
        if (r_cnt == '0) begin
          w_cand_next = w_norm;
          w_cnt_next  = CNT_W'(1);
        end else if (w_norm == r_cand) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(STABLE_CYCLES)) begin
            w_stable   = 1'b1;
            w_puc_next = r_cand;
          end
        end else begin
          w_cand_next   = w_norm;
          w_cnt_next    = CNT_W'(1);
          w_glitch_next = 1'b1;
        end
        // A stable lock on the timeout edge takes priority over the forced lock.
        if (w_stable) begin
          w_lock = 1'b1;
        end else if (w_tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
          w_puc_next     = w_norm;
          w_timeout_next = 1'b1;
          w_lock         = 1'b1;
        end
        if (w_lock) begin
          w_state_next = PUC_LOCKED;
          w_valid_next = 1'b1;
        end
      end
      PUC_LOCKED: begin
        if (w_accept) begin
          w_state_next   = PUC_SAMPLE;
          w_cnt_next     = '0;
          w_tmo_next     = '0;
          w_glitch_next  = 1'b0;
          w_timeout_next = 1'b0;
          w_valid_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = PUC_FILL;
      end
    endcase
  end

`ifdef PUC_RELATCH_EN
  logic r_ack;
  logic r_pending;
  logic r_req_low_seen;

  assign w_accept = (r_state == PUC_LOCKED) && relatch_req_i && !r_ack && r_req_low_seen;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ack          <= 1'b0;
      r_pending      <= 1'b0;
      r_req_low_seen <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (w_lock) begin
        r_pending <= 1'b0;
      end
      if (r_pending && w_lock) begin
        r_ack <= 1'b1;
      end else if (!relatch_req_i) begin
        r_ack <= 1'b0;
      end
      // Any low seen while ack is still up does not count towards the next request.
      if (w_accept || r_ack) begin
        r_req_low_seen <= 1'b0;
      end else if (!relatch_req_i) begin
        r_req_low_seen <= 1'b1;
      end
    end
  end

  assign relatch_ack_o = r_ack;
`else
  logic [1:0] w_unused_relatch;

  assign w_accept         = 1'b0;
  assign w_unused_relatch = {relatch_req_i, w_lock};
  assign relatch_ack_o    = 1'b0;
`endif

  assign puc_o         = r_puc;
  assign puc_valid_o   = r_valid;
  assign puc_glitch_o  = r_glitch;
  assign puc_timeout_o = r_timeout;

endmodule

// File: tb/tb_puc_stable.sv
// Self-checking bench for puc_stable with default parameters; honours PUC_RELATCH_EN.
module tb_puc_stable;

  localparam int NE      = 72;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 64;
  localparam logic [3:0] INV = 4'hF;

  logic       clk;
  logic       reset_i;
  logic [3:0] cap_i;
  logic       relatch_req_i;
  logic       relatch_ack_o;
  logic [3:0] puc_o;
  logic       puc_valid_o;
  logic       puc_glitch_o;
  logic       puc_timeout_o;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [3:0] c_seq [1:NE];
  logic [3:0] s_seq [1:NE];

  typedef struct {
    logic [3:0] cap;
    logic [3:0] exp_puc;
  } vec_t;

  vec_t tbl [5];

  puc_stable dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cap_i        (cap_i),
    .relatch_req_i(relatch_req_i),
    .relatch_ack_o(relatch_ack_o),
    .puc_o        (puc_o),
    .puc_valid_o  (puc_valid_o),
    .puc_glitch_o (puc_glitch_o),
    .puc_timeout_o(puc_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic start(input logic [3:0] c1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    cap_i   = c1;
    reset_i = 1'b0;
    edge_n  = 0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_puc, input logic e_vld,
                         input logic e_glt, input logic e_tmo, input logic e_ack);
    logic [7:0] act;
    logic [7:0] exp;
    act = {relatch_ack_o, puc_timeout_o, puc_glitch_o, puc_valid_o, puc_o};
    exp = {e_ack, e_tmo, e_glt, e_vld, e_puc};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got ack/tmo/glt/vld/puc=%b want=%b", tag, edge_n, act, exp);
    end
  endtask

  initial begin
    int         lock_e;
    bit         forced;
    int         run;
    logic       g;
    logic [3:0] v;
    int         d;
    int         k;

    reset_i       = 1'b1;
    cap_i         = '0;
    relatch_req_i = 1'b0;
    #2;
    chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Constant pins: lock after edge 2+STABLE with the normalised value.
    tbl[0] = '{cap: 4'b0101, exp_puc: 4'b1010};
    tbl[1] = '{cap: 4'b0000, exp_puc: 4'b1111};
    tbl[2] = '{cap: 4'b1111, exp_puc: 4'b0000};
    tbl[3] = '{cap: 4'b1001, exp_puc: 4'b0110};
    tbl[4] = '{cap: 4'b0101, exp_puc: 4'b1010};
    foreach (tbl[i]) begin
      start(tbl[i].cap);
      for (int e = 1; e <= 2 + STABLE + 2; e++) begin
        tick();
        if (e >= 2 + STABLE) chk_all("const_lock", tbl[i].exp_puc, 1'b1, 1'b0, 1'b0, 1'b0);
        else chk_all("const_pre", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

`ifdef PUC_RELATCH_EN
    // Locked on 1010; move pins to 1111 and re-latch.
    cap_i = 4'b1111;
    tick();
    tick();
    relatch_req_i = 1'b1;
    tick();
    chk_all("rl_accept", 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e < STABLE; e++) begin
      tick();
      chk_all("rl_sample", 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_all("rl_relock", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk_all("rl_ack_hold", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    relatch_req_i = 1'b0;
    tick();
    chk_all("rl_ack_fall", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    // Second re-latch needs a low cycle after ack falls; one is given above.
    cap_i = 4'b0101;
    tick();
    tick();
    relatch_req_i = 1'b1;
    tick();
    chk_all("rl2_accept", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (STABLE) tick();
    chk_all("rl2_relock", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
    relatch_req_i = 1'b0;
    tick();
    chk_all("rl2_ack_fall", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    // Without the handshake a held request must not disturb the lock.
    relatch_req_i = 1'b1;
    for (int e = 0; e < 12; e++) begin
      cap_i = 4'($urandom);
      tick();
      chk_all("req_ignored", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    relatch_req_i = 1'b0;
`endif

    // Bit0 toggles at edge 6: glitch at edge 8, lock 8 samples later at edge 15.
    start(4'b0101);
    for (int e = 1; e <= 20; e++) begin
      cap_i = (e >= 6) ? 4'b0100 : 4'b0101;
      tick();
      chk_all("glitch_seq", (e >= 15) ? 4'b1011 : 4'b0000, e >= 15, e >= 8, 1'b0, 1'b0);
    end

    // Pins toggle every 3 cycles: forced lock at edge 66 with sample from pins at edge 64.
    start(4'b0101);
    for (int e = 1; e <= 70; e++) begin
      cap_i = (((e - 1) / 3) % 2 == 1) ? 4'b1010 : 4'b0101;
      tick();
      if (e >= 60) chk_all("timeout_seq", (e >= 66) ? 4'b0101 : 4'b0000, e >= 66, 1'b1,
                           e >= 66, 1'b0);
    end

    // Asynchronous reset mid-SAMPLE with glitch set, then again in LOCKED.
    start(4'b0101);
    for (int e = 1; e <= 9; e++) begin
      cap_i = (e >= 6) ? 4'b0100 : 4'b0101;
      tick();
    end
    chk_all("pre_rst_sample", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset_i = 1'b1;
    #1 chk_all("rst_sample", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    start(4'b0011);
    for (int e = 1; e <= 2 + STABLE; e++) tick();
    chk_all("restart_lock", 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset_i = 1'b1;
    #1 chk_all("rst_locked", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    start(4'b0011);
    for (int e = 1; e <= 2 + STABLE; e++) begin
      tick();
      if (e == 1 + STABLE) chk_all("restart2_pre", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_all("restart2_lock", 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random pin histories against a sequence-level model of the contract.
    for (int t = 0; t < 24; t++) begin
      k = 1;
      while (k <= NE) begin
        v = 4'($urandom);
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 9);
        for (int j = 0; j < d && k <= NE; j++) begin
          c_seq[k] = v;
          k++;
        end
      end
      for (int e = 3; e <= NE; e++) s_seq[e] = c_seq[e-2] ^ INV;
      lock_e = 0;
      forced = 1'b0;
      run    = 0;
      for (int e = 3; e <= TIMEOUT + 2; e++) begin
        if (lock_e == 0) begin
          run = (e > 3 && s_seq[e] == s_seq[e-1]) ? run + 1 : 1;
          if (run == STABLE) begin
            lock_e = e;
          end else if (e == TIMEOUT + 2) begin
            lock_e = e;
            forced = 1'b1;
          end
        end
      end
      g = 1'b0;
      start(c_seq[1]);
      for (int e = 1; e <= NE; e++) begin
        cap_i = c_seq[e];
`ifndef PUC_RELATCH_EN
        relatch_req_i = 1'($urandom_range(0, 1));
`endif
        tick();
        if (e >= 4 && e <= lock_e && s_seq[e] != s_seq[e-1]) g = 1'b1;
        chk_all("random", (e >= lock_e) ? s_seq[lock_e] : 4'h0, e >= lock_e, g,
                forced && (e >= lock_e), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
